shift_rotate_unit: RTL and testbench
====================================

# shift_rotate_unit

Parametrised multi-mode shift/rotate register with parallel load, serial input and a start/busy/done handshake. It performs multi-position shifts one bit position per clock under a small FSM. The block is the datapath register for the lab ALU/register-file work and replaces the fixed 8-bit rotate register. Any datapath that needs logical or arithmetic shifts, rotates or a serial-in shift can attach to the handshake.

## Interface
- WIDTH, 8, register width in bits (≥ 2)
- SHAMT_W, 3, width of shift-amount input
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  3  operation code (see Operation)
- shamt  in  SHAMT_W  number of bit positions to shift/rotate
- data_in  in  WIDTH  parallel load value
- ser_in  in  1  serial fill bit for SRI
- q  out  WIDTH  register contents
- ser_out  out  1  bit most recently shifted/rotated out
- busy  out  1  high while in SHIFT state
- done  out  1  one-cycle completion pulse

## Operation
- Ops:
  - 000 LOAD: q←data_in.
  - 001 ROR: rotate right.
  - 010 ROL: rotate left.
  - 011 LSR: shift right, 0 fill.
  - 100 LSL: shift left, 0 fill.
  - 101 ASR: shift right, MSB replicated.
  - 110 SRI: shift right, MSB←ser_in.
  - 111 CLEAR: q←0.
- FSM states: IDLE, SHIFT.
- IDLE + start, op LOAD/CLEAR: applied at that edge; stay IDLE; done=1 next cycle; busy never asserts.
- IDLE + start, shift op (001–110), shamt=0: q unchanged; stay IDLE; done=1 next cycle.
- IDLE + start, shift op, shamt=k>0: latch op and k into internal op_r/cnt; go to SHIFT.
- SHIFT, each edge: q moves one position per op_r; ser_out←outgoing bit (old q[0] for right ops, old q[WIDTH-1] for left ops); cnt decrements. When cnt==1 at the edge, go to IDLE and set done.
- ser_in is sampled live on each SRI shift edge. op, shamt and data_in are ignored after acceptance.
- shamt may exceed WIDTH; it is iterated literally. Rotates wrap naturally; LSR/LSL ≥ WIDTH gives 0; ASR ≥ WIDTH gives all copies of the sign bit.
- start while in SHIFT is ignored; no queuing.
- start in the cycle where done=1 (FSM in IDLE) is accepted normally.
- LOAD and CLEAR leave ser_out unchanged.
- No output is combinational from inputs; all outputs are registered.

## Timing
- Reset (async, any state): q=0, ser_out=0, busy=0, done=0, state IDLE, cnt=0. Takes effect immediately and overrides an operation in flight; no done is produced for the aborted operation.
- Shift of k>0 accepted at edge t: busy=1 after edges t..t+k-1, i.e. k cycles. q updates at edges t+1..t+k. After edge t+k: busy=0, done=1 for exactly one cycle, q holds the final value.
- LOAD/CLEAR/shamt=0 at edge t: q is final after edge t; done=1 for the cycle after edge t.
- Throughput: one k-bit shift per k+1 cycles with back-to-back starts. Single-cycle ops achieve one per cycle.

## Test plan
- Reset; LOAD data_in=0xA5 → q=0xA5 after one edge; done pulses 1 cycle; busy stays 0; ser_out=0.
- From 0xA5, ROR shamt=3 → busy 3 cycles; q steps 0xD2, 0x69, 0xB4; ser_out=1; done 1 cycle after last step.
- From 0x80, ASR shamt=7 → q=0xFF. LOAD 0x81, then LSL shamt=7 → q=0x80, ser_out=0.
- From 0x00, SRI shamt=4 with ser_in 1,0,1,1 on successive shift edges → q=0xD0. ROL shamt=0 → done next cycle, q unchanged, busy never 1.
- During a 5-step LSR: assert start with LOAD and change data_in/op → ignored, result unaffected. Assert start in the done cycle → accepted.
- resetn low after 2 of 5 ROL edges (mid-cycle, asynchronous) → q, ser_out, busy, done immediately 0. After release, no done pulse; a new LOAD works.

Source files
------------

// File: rtl/shift_rotate_unit.sv
// shift_rotate_unit: multi-mode shift/rotate register with parallel load,
// serial input and a start/busy/done handshake. A multi-position shift
// moves one bit position per clock.
module shift_rotate_unit #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = 3
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               ser_in,
  output logic [WIDTH-1:0]   q,
  output logic               ser_out,
  output logic               busy,
  output logic               done
);

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_LOAD  = 3'b000;
  localparam logic [OP_W-1:0] OP_ROR   = 3'b001;
  localparam logic [OP_W-1:0] OP_ROL   = 3'b010;
  localparam logic [OP_W-1:0] OP_LSR   = 3'b011;
  localparam logic [OP_W-1:0] OP_LSL   = 3'b100;
  localparam logic [OP_W-1:0] OP_ASR   = 3'b101;
  localparam logic [OP_W-1:0] OP_SRI   = 3'b110;
  localparam logic [OP_W-1:0] OP_CLEAR = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   reg_q, reg_d;
  logic               ser_q, ser_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // One-position step of the latched operation and the bit it pushes out
  logic [WIDTH-1:0]   step_val_c;
  logic               step_out_c;

  // Single-position shift/rotate datapath for the operation held in op_q
  always_comb begin
    step_val_c = reg_q;
    step_out_c = ser_q;
    case (op_q)
      OP_ROR: begin
        step_val_c = {reg_q[0], reg_q[WIDTH-1:1]};
        step_out_c = reg_q[0];
      end
      OP_ROL: begin
        step_val_c = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
        step_out_c = reg_q[WIDTH-1];
      end
      OP_LSR: begin
        step_val_c = {1'b0, reg_q[WIDTH-1:1]};
        step_out_c = reg_q[0];
      end
      OP_LSL: begin
        step_val_c = {reg_q[WIDTH-2:0], 1'b0};
        step_out_c = reg_q[WIDTH-1];
      end
      OP_ASR: begin
        step_val_c = {reg_q[WIDTH-1], reg_q[WIDTH-1:1]};
        step_out_c = reg_q[0];
      end
      OP_SRI: begin
        // ser_in is sampled live on every SRI step
        step_val_c = {ser_in, reg_q[WIDTH-1:1]};
        step_out_c = reg_q[0];
      end
      default: begin
        step_val_c = reg_q;
        step_out_c = ser_q;
      end
    endcase
  end

  // Next-state and registered-output logic for the IDLE/SHIFT controller
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    reg_d   = reg_q;
    ser_d   = ser_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_LOAD: begin
              reg_d  = data_in;
              done_d = 1'b1;
            end
            OP_CLEAR: begin
              reg_d  = '0;
              done_d = 1'b1;
            end
            default: begin
              if (shamt == '0) begin
                // Zero-length shift completes immediately with q untouched
                done_d = 1'b1;
              end else begin
                op_d    = op;
                cnt_d   = shamt;
                state_d = ST_SHIFT;
              end
            end
          endcase
        end
      end
      ST_SHIFT: begin
        // start is deliberately ignored here; there is no request queue
        reg_d = step_val_c;
        ser_d = step_out_c;
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_SHIFT);
  end

  // State and output registers; reset aborts any shift without a done pulse
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      cnt_q   <= '0;
      reg_q   <= '0;
      ser_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      reg_q   <= reg_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q       = reg_q;
  assign ser_out = ser_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Directed bench for shift_rotate_unit with hand-computed expectations.
module tb_shift_rotate_unit;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned SHAMT_W = 3;

  logic               clock;
  logic               resetn;
  logic               start;
  logic [2:0]         op;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   data_in;
  logic               ser_in;
  logic [WIDTH-1:0]   q;
  logic               ser_out;
  logic               busy;
  logic               done;

  int n_checks;
  int n_fails;

  shift_rotate_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .start   (start),
    .op      (op),
    .shamt   (shamt),
    .data_in (data_in),
    .ser_in  (ser_in),
    .q       (q),
    .ser_out (ser_out),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] eq, input logic es,
                           input logic eb, input logic ed);
    check({tag, ".q"},       32'(q),       32'(eq));
    check({tag, ".ser_out"}, 32'(ser_out), 32'(es));
    check({tag, ".busy"},    32'(busy),    32'(eb));
    check({tag, ".done"},    32'(done),    32'(ed));
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    resetn   = 1'b0;
    start    = 1'b0;
    op       = 3'b000;
    shamt    = '0;
    data_in  = '0;
    ser_in   = 1'b0;

    #12;
    check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    resetn = 1'b1;
    step();

    // LOAD 0xA5
    start = 1'b1; op = 3'b000; data_in = 8'hA5;
    step();
    start = 1'b0;
    check_all("load_a5", 8'hA5, 1'b0, 1'b0, 1'b1);
    step();
    check("load_a5_done_drop", 32'(done), 32'd0);

    // ROR by 3 from 0xA5
    start = 1'b1; op = 3'b001; shamt = 3'd3;
    step();
    start = 1'b0;
    check_all("ror_accept", 8'hA5, 1'b0, 1'b1, 1'b0);
    step();
    check_all("ror_s1", 8'hD2, 1'b1, 1'b1, 1'b0);
    step();
    check_all("ror_s2", 8'h69, 1'b0, 1'b1, 1'b0);
    step();
    check_all("ror_s3", 8'hB4, 1'b1, 1'b0, 1'b1);
    step();
    check("ror_done_drop", 32'(done), 32'd0);

    // LOAD 0x80 leaves ser_out at 1, then ASR by 7
    start = 1'b1; op = 3'b000; data_in = 8'h80;
    step();
    check_all("load_80", 8'h80, 1'b1, 1'b0, 1'b1);
    op = 3'b101; shamt = 3'd7;
    step();
    start = 1'b0;
    check_all("asr_accept", 8'h80, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step();
    check("asr_busy_s6", 32'(busy), 32'd1);
    step();
    check_all("asr_final", 8'hFF, 1'b0, 1'b0, 1'b1);

    // LOAD 0x81 then LSL by 7
    start = 1'b1; op = 3'b000; data_in = 8'h81;
    step();
    check("load_81", 32'(q), 32'h81);
    op = 3'b100; shamt = 3'd7;
    step();
    start = 1'b0;
    step();
    check_all("lsl_s1", 8'h02, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step();
    check_all("lsl_final", 8'h80, 1'b0, 1'b0, 1'b1);

    // CLEAR then SRI by 4 with ser_in 1,0,1,1
    start = 1'b1; op = 3'b111;
    step();
    check_all("clear", 8'h00, 1'b0, 1'b0, 1'b1);
    op = 3'b110; shamt = 3'd4;
    step();
    start = 1'b0;
    ser_in = 1'b1;
    step();
    check("sri_s1", 32'(q), 32'h80);
    ser_in = 1'b0;
    step();
    check("sri_s2", 32'(q), 32'h40);
    ser_in = 1'b1;
    step();
    check("sri_s3", 32'(q), 32'hA0);
    ser_in = 1'b1;
    step();
    check_all("sri_final", 8'hD0, 1'b0, 1'b0, 1'b1);
    ser_in = 1'b0;
    step();

    // ROL by 0 completes next cycle without busy
    start = 1'b1; op = 3'b010; shamt = 3'd0;
    step();
    start = 1'b0;
    check_all("rol0", 8'hD0, 1'b0, 1'b0, 1'b1);
    step();
    check_all("rol0_after", 8'hD0, 1'b0, 1'b0, 1'b0);

    // LSR by 5 from 0xFF with a LOAD request held throughout
    start = 1'b1; op = 3'b000; data_in = 8'hFF;
    step();
    op = 3'b011; shamt = 3'd5;
    step();
    check("lsr_accept_busy", 32'(busy), 32'd1);
    op = 3'b000; data_in = 8'h00; shamt = 3'd7;
    for (int i = 0; i < 4; i++) begin
      step();
      check("lsr_busy_mid", 32'(busy), 32'd1);
    end
    step();
    check_all("lsr_final", 8'h07, 1'b1, 1'b0, 1'b1);
    data_in = 8'h3C;
    step();
    start = 1'b0;
    check_all("load_in_done", 8'h3C, 1'b1, 1'b0, 1'b1);
    step();

    // ROL by 5 aborted by asynchronous reset after 2 steps
    start = 1'b1; op = 3'b010; shamt = 3'd5;
    step();
    start = 1'b0;
    step();
    step();
    check("rol_s2", 32'(q), 32'hF0);
    #2;
    resetn = 1'b0;
    #1;
    check_all("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("no_done_after_abort", 32'(done), 32'd0);
    end
    start = 1'b1; op = 3'b000; data_in = 8'h5A;
    step();
    start = 1'b0;
    check_all("load_after_reset", 8'h5A, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
